// File: rtl/sqrt_pkg.sv
// Shared definitions for the sequential integer square-root extractor:
// FSM state type, default radicand width and root-width helper.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 6;

  function automatic int unsigned sqrt_rw(input int unsigned width);
    return width / 2;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One digit iteration of the restoring square-root algorithm:
// bring down two radicand bits, try subtracting (root<<2)|1, and
// append the resulting root bit. Purely combinational.
module sqrt_step #(
  parameter int unsigned RW = 3
) (
  input  logic [RW+1:0] rem_in,
  input  logic [RW-1:0] root_in,
  input  logic [1:0]    bits,
  output logic [RW+1:0] rem_out,
  output logic [RW-1:0] root_out
);

  logic [RW+3:0] rem_sh;
  logic [RW+3:0] trial;

  // Shift in two radicand bits and resolve the next root bit.
  always_comb begin
    rem_sh   = {rem_in, bits};
    trial    = {2'b00, root_in, 2'b01};
    rem_out  = (RW+2)'(rem_sh);
    root_out = RW'({root_in, 1'b0});
    if (rem_sh >= trial) begin
      rem_out  = (RW+2)'(rem_sh - trial);
      root_out = RW'({root_in, 1'b1});
    end
  end

endmodule

// File: rtl/seq_int_sqrt.sv
// Iterative integer square root: root = floor(sqrt(radicand)),
// remainder = radicand - root^2, one root bit resolved per clock.
// Valid/ready handshake on both sides; no overlap between results.
// Optional output `exact` (perfect-square flag) under SQRT_EXACT_FLAG_EN.
module seq_int_sqrt
  import sqrt_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned RW    = sqrt_rw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] radicand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    root,
  output logic [RW:0]      remainder
`ifdef SQRT_EXACT_FLAG_EN
  ,
  output logic             exact
`endif
);

  localparam int unsigned CW = $clog2(RW + 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("seq_int_sqrt: WIDTH must be even and at least 2");
  end

  state_t          state;
  logic [WIDTH-1:0] rad_q;
  logic [RW+1:0]    rem_q;
  logic [RW-1:0]    part_q;
  logic [CW-1:0]    cnt;

  logic [RW+1:0]    rem_nxt;
  logic [RW-1:0]    part_nxt;

  sqrt_step #(
    .RW(RW)
  ) u_step (
    .rem_in   (rem_q),
    .root_in  (part_q),
    .bits     (rad_q[WIDTH-1 -: 2]),
    .rem_out  (rem_nxt),
    .root_out (part_nxt)
  );

  // Handshake FSM with iteration registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      root      <= '0;
      remainder <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      part_q    <= '0;
      cnt       <= '0;
`ifdef SQRT_EXACT_FLAG_EN
      exact     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            rad_q    <= radicand;
            rem_q    <= '0;
            part_q   <= '0;
            cnt      <= CW'(RW);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          rad_q  <= rad_q << 2;
          rem_q  <= rem_nxt;
          part_q <= part_nxt;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            root      <= part_nxt;
            remainder <= rem_nxt[RW:0];
`ifdef SQRT_EXACT_FLAG_EN
            exact     <= (rem_nxt == '0);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_int_sqrt.sv
// Self-checking bench for seq_int_sqrt: directed cases, backpressure,
// mid-computation reset, and an exhaustive sweep with random stalls and
// input noise, all checked against a plain-arithmetic square-root model.
module tb_seq_int_sqrt;

  localparam int unsigned W     = 6;
  localparam int unsigned R     = W / 2;
  localparam int unsigned BOUND = 4 * R + 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] radicand;
  logic         out_valid;
  logic         out_ready;
  logic [R-1:0] root;
  logic [R:0]   remainder;
`ifdef SQRT_EXACT_FLAG_EN
  logic         exact;
`endif

  int checks = 0;
  int errors = 0;
  int handshakes = 0;
  int runs = 0;

  seq_int_sqrt #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .radicand  (radicand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .remainder (remainder)
`ifdef SQRT_EXACT_FLAG_EN
    ,
    .exact     (exact)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) handshakes++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ref_sqrt(input int unsigned x);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic run_one(input int unsigned x, input int unsigned stall, input bit noise);
    int unsigned k;
    bit got;
    int unsigned er, erem, hr, hrem;
    er   = ref_sqrt(x);
    erem = x - er * er;
    radicand = W'(x);
    in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    runs++;
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    k = 0;
    got = 1'b0;
    while (!got && k < BOUND) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        radicand  = W'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end
      tick();
      k++;
      if (out_valid) got = 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = (stall == 0);
    check("result_arrived", 32'(got), 32'd1);
    check("latency", k, R);
    check("root", 32'(root), er);
    check("remainder", 32'(remainder), erem);
    hr   = root;
    hrem = remainder;
    check("root_bounds", 32'((hr * hr <= x) && (x < (hr + 1) * (hr + 1)) && (hrem == x - hr * hr)), 32'd1);
`ifdef SQRT_EXACT_FLAG_EN
    check("exact", 32'(exact), 32'(erem == 0));
`endif
    for (int unsigned s = 0; s < stall; s++) begin
      tick();
      check("held_valid", 32'(out_valid), 32'd1);
      check("held_in_ready", 32'(in_ready), 32'd0);
      check("held_root", 32'(root), er);
      check("held_rem", 32'(remainder), erem);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    radicand = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_root", 32'(root), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
`ifdef SQRT_EXACT_FLAG_EN
    check("rst_exact", 32'(exact), 32'd0);
`endif
    rst = 1'b0;

    // out_ready while idle has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_out_ready_valid", 32'(out_valid), 32'd0);

    run_one(0, 0, 1'b0);
    run_one(49, 0, 1'b0);
    run_one(50, 0, 1'b0);
    run_one(63, 0, 1'b0);
    run_one(36, 10, 1'b0);

    // abort mid-computation
    radicand = W'(48);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_root", 32'(root), 32'd0);
    check("abort_rem", 32'(remainder), 32'd0);
    tick();
    check("abort_stays_idle", 32'(out_valid), 32'd0);
    run_one(16, 0, 1'b0);

    // exhaustive sweep with input noise during CALC and random stalls
    for (int unsigned x = 0; x < (1 << W); x++) begin
      run_one(x, $urandom_range(0, 3), 1'b1);
    end

    tick();
    check("handshake_count", handshakes, runs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
